// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: mult/div occupancy state encoding and defaults.
package cpu_pkg;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_e;

  localparam int unsigned MUL_CYCLES_DEFAULT = 4;
  localparam int unsigned DIV_CYCLES_DEFAULT = 16;
  localparam logic [4:0]  REG_ZERO           = 5'd0;

endpackage

// File: rtl/md_occupancy_timer.sv
// Tracks how long the EX-stage HI/LO unit stays occupied after a mult/div issues.
module md_occupancy_timer
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic ex_md_start,
  input  logic ex_md_is_div,
  output logic md_busy,
  output logic md_wait
);

  md_state_e  state_q, state_d;
  logic [4:0] md_cnt_q, md_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_RUN;
      md_cnt_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt_q;
    unique case (state_q)
      ST_RUN: begin
        if (ex_md_start) begin
          state_d  = ST_MD_WAIT;
          // Issue cycle plus the final md_cnt==0 cycle account for the -2.
          md_cnt_d = ex_md_is_div ? 5'(DIV_CYCLES - 2) : 5'(MUL_CYCLES - 2);
        end
      end
      ST_MD_WAIT: begin
        // A start seen here is illegal and deliberately ignored.
        if (md_cnt_q == 5'd0) begin
          state_d = ST_RUN;
        end else begin
          md_cnt_d = md_cnt_q - 5'd1;
        end
      end
      default: begin
        state_d  = ST_RUN;
        md_cnt_d = 5'd0;
      end
    endcase
  end

  assign md_wait = ~reset & (state_q == ST_MD_WAIT);
  assign md_busy = md_wait | (~reset & ex_md_start);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall/flush controller: load-use and HI/LO occupancy hazards, branch flush,
// and a free-running stall-cycle counter.
module hazard_stall_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEFAULT,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEFAULT,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_access,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             ex_md_start,
  input  logic             ex_md_is_div,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  logic             md_wait;
  logic             load_use;
  logic             md_hazard;
  logic             stall;
  logic [CNT_W-1:0] stall_count_q;

  md_occupancy_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md_timer (
    .clk          (clk),
    .reset        (reset),
    .ex_md_start  (ex_md_start),
    .ex_md_is_div (ex_md_is_div),
    .md_busy      (md_busy),
    .md_wait      (md_wait)
  );

  assign load_use  = ex_mem_read & (ex_rt != REG_ZERO) &
                     ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  assign md_hazard = id_md_access & (md_wait | ex_md_start);
  assign stall     = ~reset & (load_use | md_hazard);

  // A branch resolved during a stall may still change, so it only flushes once unstalled.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (stall) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else if (~reset & branch_taken) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count_q <= '0;
    end else if (stall) begin
      stall_count_q <= stall_count_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed checks of hazard_stall_ctrl: load-use, zero/rt gating, mult/div occupancy,
// branch-during-stall and reset mid-divide.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, id_md_access, ex_mem_read, ex_md_start, ex_md_is_div;
  logic        branch_taken;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_stall_ctrl #(
    .MUL_CYCLES (4),
    .DIV_CYCLES (16),
    .CNT_W      (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .id_md_access (id_md_access),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .ex_md_start  (ex_md_start),
    .ex_md_is_div (ex_md_is_div),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .md_busy      (md_busy),
    .stall_count  (stall_count)
  );

  always #5 clk = ~clk;

  // Advance one clock edge, then let the new inputs settle away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Control vector order: {pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy}.
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    #1;
    obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble, md_busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed ctl=%b expected ctl=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    checks++;
    assert (stall_count === exp) else begin
      errors++;
      $error("FAIL %s: observed stall_count=%0d expected stall_count=%0d",
             tag, stall_count, exp);
    end
  endtask

  localparam logic [4:0] NORMAL   = 5'b11000;
  localparam logic [4:0] STALLED  = 5'b00010;
  localparam logic [4:0] MD_STALL = 5'b00011;
  localparam logic [4:0] MD_FREE  = 5'b11001;
  localparam logic [4:0] FLUSHED  = 5'b11100;

  initial begin
    reset = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_md_access = 1'b0; ex_mem_read = 1'b0;
    ex_md_start = 1'b0; ex_md_is_div = 1'b0; branch_taken = 1'b0;
    cyc();
    chk_ctl("reset_outputs", NORMAL);
    // Hazards presented during reset must be masked.
    ex_md_start = 1'b1; id_md_access = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    chk_ctl("reset_masks_hazards", NORMAL);
    cyc();
    chk_cnt("reset_count", 32'd0);
    ex_md_start = 1'b0; id_md_access = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0;
    reset = 1'b0;
    cyc();
    chk_cnt("after_reset_count", 32'd0);

    // Load-use via rs
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    chk_ctl("load_use_rs", STALLED);
    cyc();
    ex_mem_read = 1'b0;
    chk_ctl("load_use_release", NORMAL);
    chk_cnt("load_use_count", 32'd1);

    // Load into $zero never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    chk_ctl("zero_reg_no_stall", NORMAL);
    cyc();
    chk_cnt("zero_reg_count", 32'd1);

    // rt match gated by id_uses_rt
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    chk_ctl("rt_unused_no_stall", NORMAL);
    cyc();
    id_uses_rt = 1'b1;
    chk_ctl("rt_used_stall", STALLED);
    cyc();
    ex_mem_read = 1'b0; id_uses_rt = 1'b0;
    chk_ctl("rt_release", NORMAL);
    chk_cnt("rt_count", 32'd2);

    // Multiply occupancy with HI/LO reader held in ID
    ex_md_start = 1'b1; ex_md_is_div = 1'b0; id_md_access = 1'b1;
    chk_ctl("mul_c0", MD_STALL);
    cyc();
    ex_md_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk_ctl($sformatf("mul_c%0d", c), MD_STALL);
      cyc();
    end
    chk_ctl("mul_c4_release", NORMAL);
    chk_cnt("mul_count", 32'd6);
    id_md_access = 1'b0;

    // Divide with unrelated ID instruction; a stray start mid-wait must not reload
    ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    chk_ctl("div_c0", MD_FREE);
    cyc();
    ex_md_start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (c == 3) begin
        ex_md_start = 1'b1; ex_md_is_div = 1'b0;
      end else begin
        ex_md_start = 1'b0;
      end
      chk_ctl($sformatf("div_c%0d", c), MD_FREE);
      cyc();
    end
    ex_md_start = 1'b0;
    chk_ctl("div_c16_idle", NORMAL);
    chk_cnt("div_count", 32'd6);

    // Branch during load-use stall must not flush
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
    chk_ctl("branch_in_stall", STALLED);
    cyc();
    ex_mem_read = 1'b0;
    chk_ctl("branch_flush", FLUSHED);
    cyc();
    branch_taken = 1'b0;
    chk_cnt("branch_count", 32'd7);

    // Load-use and md_hazard together count once per cycle
    ex_md_start = 1'b1; ex_md_is_div = 1'b0; id_md_access = 1'b1; ex_mem_read = 1'b1;
    chk_ctl("both_c0", MD_STALL);
    cyc();
    ex_md_start = 1'b0; ex_mem_read = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk_ctl($sformatf("both_c%0d", c), MD_STALL);
      cyc();
    end
    chk_ctl("both_release", NORMAL);
    chk_cnt("both_count", 32'd11);
    id_md_access = 1'b0;

    // Reset mid-divide
    ex_md_start = 1'b1; ex_md_is_div = 1'b1;
    cyc();
    ex_md_start = 1'b0;
    for (int c = 1; c <= 4; c++) cyc();
    chk_ctl("div_before_reset", MD_FREE);
    reset = 1'b1;
    chk_ctl("reset_mid_div", NORMAL);
    cyc();
    reset = 1'b0; id_md_access = 1'b1;
    chk_ctl("post_reset_no_stall", NORMAL);
    chk_cnt("post_reset_count", 32'd0);
    cyc();
    chk_cnt("post_reset_count2", 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
